cv32e40p_ft_error_monitor: RTL and testbench
============================================

CV32E40P_FT_ERROR_MONITOR -- requirements
Module: cv32e40p_ft_error_monitor

Interface
REQ-001 SHALL provide parameter NSRC, default 4: number of error sources, one per voter error_detected line.
REQ-002 SHALL provide parameter CNT_W, default 8: width of each per-source saturating counter.
REQ-003 SHALL provide parameter PERSIST_CYCLES, default 4: consecutive-cycle threshold for permanent-fault detection (valid range 2..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 SHALL have port err_i  input  NSRC  voter error_detected flags; bit k high = mismatch on source k this cycle.
REQ-007 SHALL have port clear_i  input  1  synchronous clear of sticky flags, counters and permanent flags.
REQ-008 SHALL have port rd_sel_i  input  $clog2(NSRC)  source index selected for counter readout.
REQ-009 SHALL have port rd_cnt_o  output  CNT_W  counter of source rd_sel_i, combinational mux of registered counters.
REQ-010 SHALL have port sticky_o  output  NSRC  sticky per-source error flags.
REQ-011 SHALL have port total_cnt_o  output  16  count of cycles with any err_i bit high, saturating.
REQ-012 SHALL have port first_src_o  output  $clog2(NSRC)  lowest-index source of the currently reported event.
REQ-013 SHALL have port irq_o  output  1  error-report request, level until acknowledged.
REQ-014 SHALL have port irq_ack_i  input  1  report acknowledge from the handler.
REQ-015 SHALL have port perm_fault_o  output  NSRC  sticky permanent-fault flags.

Function
REQ-016 SHALL set sticky_o[k] the cycle after err_i[k]=1; held until clear_i or reset.
REQ-017 SHALL increment counter k by 1 per cycle err_i[k]=1; saturate at 2^CNT_W-1, no wrap.
REQ-018 SHALL increment total_cnt_o by exactly 1 per cycle with any err_i bit set, regardless of how many; saturate at 0xFFFF.
REQ-019 SHALL give clear_i priority over err_i in the same cycle: flags/counters go to 0; that cycle's errors are dropped.
REQ-020 SHALL implement FSM IDLE, REPORT, HOLDOFF; irq_o=1 only in REPORT.
REQ-021 SHALL go IDLE->REPORT when err_i!=0 and clear_i=0, capturing first_src_o = lowest set index of err_i.
REQ-022 SHALL go REPORT->HOLDOFF on the first cycle irq_ack_i=1 in REPORT; irq_ack_i outside REPORT is ignored.
REQ-023 SHALL set pending and capture the lowest index of the first such error in pending_src when errors arrive in REPORT or HOLDOFF; later errors do not overwrite pending_src.
REQ-024 SHALL stay in HOLDOFF exactly one cycle, then go to REPORT (first_src_o<=pending_src, pending cleared) if pending, else to IDLE.
REQ-025 SHALL, on clear_i, force FSM to IDLE, clear pending and irq_o next cycle; first_src_o holds its value.
REQ-026 SHALL hold first_src_o stable while in REPORT.

Reset
REQ-027 SHALL, on rst_n=0, asynchronously drive: FSM IDLE, irq_o 0, sticky_o 0, all counters 0, total_cnt_o 0, first_src_o 0, pending 0, perm_fault_o 0, run counters 0.
REQ-028 SHALL abort any in-progress report when reset asserts mid-REPORT; no irq_o after release until a new error.

Configuration
REQ-029 SHALL, with macro CV32E40P_FT_PERSIST_EN defined, keep a per-source run counter (reset to 0 on any cycle err_i[k]=0 or clear_i) and set perm_fault_o[k] the cycle after err_i[k] has been 1 for PERSIST_CYCLES consecutive cycles; sticky until clear_i/reset.
REQ-030 SHALL, without CV32E40P_FT_PERSIST_EN, omit run counters and tie perm_fault_o to 0; all other behaviour unchanged.

Verification
REQ-031 SHALL cover: err_i=4'b0100 one cycle -> next cycle sticky_o=4'b0100, irq_o=1, first_src_o=2, rd_sel_i=2 gives rd_cnt_o=1, total_cnt_o=1.
REQ-032 SHALL cover: err_i=4'b1010 for 300 cycles, CNT_W=8 -> rd_cnt_o(sel 1)=255, total_cnt_o=300, first_src_o=1.
REQ-033 SHALL cover: in REPORT, err_i=4'b1000 then irq_ack_i=1 -> HOLDOFF one cycle with irq_o=0, then irq_o=1 with first_src_o=3.
REQ-034 SHALL cover: clear_i=1 with err_i=4'b0001 same cycle -> next cycle sticky_o=0, counters 0, irq_o=0, FSM IDLE.
REQ-035 SHALL cover, macro on: err_i[0]=1 for 3 cycles, gap, then 4 cycles -> perm_fault_o[0]=0 after the first run, =1 the cycle after the 4th; macro off -> perm_fault_o stays 0.
REQ-036 SHALL cover: rst_n=0 asserted mid-REPORT without clock edge -> irq_o and all outputs 0 immediately.

Source files
------------

// File: rtl/cv32e40p_ft_error_monitor.sv
// cv32e40p_ft_error_monitor
// Collects the error_detected lines of the fault-tolerant voters. For each
// source it keeps a sticky flag and a saturating error counter, plus one
// global count of cycles in which any source was in error. A small report
// FSM (IDLE / REPORT / HOLDOFF) raises irq_o for one event at a time. An event
// that arrives while a report is open or in holdoff is remembered as pending
// and reported after the holdoff cycle.
// Optional feature: define CV32E40P_FT_PERSIST_EN to enable permanent-fault
// detection. A source is flagged when its error line stays high for
// PERSIST_CYCLES consecutive cycles. Without the macro, perm_fault_o is
// tied to zero.
module cv32e40p_ft_error_monitor #(
    parameter int NSRC           = 4,
    parameter int CNT_W          = 8,
    parameter int PERSIST_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NSRC-1:0]         err_i,
    input  logic                    clear_i,
    input  logic [$clog2(NSRC)-1:0] rd_sel_i,
    output logic [CNT_W-1:0]        rd_cnt_o,
    output logic [NSRC-1:0]         sticky_o,
    output logic [15:0]             total_cnt_o,
    output logic [$clog2(NSRC)-1:0] first_src_o,
    output logic                    irq_o,
    input  logic                    irq_ack_i,
    output logic [NSRC-1:0]         perm_fault_o
);

    localparam int               SEL_W   = $clog2(NSRC);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [15:0]      TOT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REPORT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Return the lowest index whose bit is set. An all-zero input returns 0.
    function automatic logic [SEL_W-1:0] lowest_idx(input logic [NSRC-1:0] v);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = SEL_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [NSRC-1:0]  r_sticky;
    logic [CNT_W-1:0] r_cnt [NSRC];
    logic [15:0]      r_total;
    state_t           r_state;
    logic             r_irq;
    logic [SEL_W-1:0] r_first;
    logic             r_pend;
    logic [SEL_W-1:0] r_pend_src;
    logic             w_any_err;
    logic [SEL_W-1:0] w_low;
    logic [CNT_W-1:0] w_rd_cnt;

    assign w_any_err = |err_i;
    assign w_low     = lowest_idx(err_i);

    // Update the sticky flags, the per-source saturating counters and the global error-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
            r_cnt    <= '{default: '0};
            r_total  <= '0;
        end else if (clear_i) begin
            // A clear takes priority over errors seen in the same cycle, so those errors are dropped.
            r_sticky <= '0;
            r_cnt    <= '{default: '0};
            r_total  <= '0;
        end else begin
            r_sticky <= r_sticky | err_i;
            for (int k = 0; k < NSRC; k++) begin
                if (err_i[k] && (r_cnt[k] != CNT_MAX)) begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end else begin
                    r_cnt[k] <= r_cnt[k];
                end
            end
            // The global count advances by one per erroneous cycle, however many sources are in error.
            if (w_any_err && (r_total != TOT_MAX)) begin
                r_total <= r_total + 16'd1;
            end else begin
                r_total <= r_total;
            end
        end
    end

    // Report FSM. irq_o is registered and is high exactly while the FSM is in REPORT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_irq      <= 1'b0;
            r_first    <= '0;
            r_pend     <= 1'b0;
            r_pend_src <= '0;
        end else if (clear_i) begin
            // first_src_o keeps its last value across a clear.
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_err) begin
                        r_state <= ST_REPORT;
                        r_irq   <= 1'b1;
                        r_first <= w_low;
                    end else begin
                        r_state <= ST_IDLE;
                        r_irq   <= 1'b0;
                    end
                end
                ST_REPORT: begin
                    // Only the first event of a burst is remembered; later errors do not overwrite it.
                    if (w_any_err && !r_pend) begin
                        r_pend     <= 1'b1;
                        r_pend_src <= w_low;
                    end else begin
                        r_pend     <= r_pend;
                    end
                    if (irq_ack_i) begin
                        r_state <= ST_HOLDOFF;
                        r_irq   <= 1'b0;
                    end else begin
                        r_state <= ST_REPORT;
                        r_irq   <= 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    // An error arriving in the holdoff cycle itself also counts as pending.
                    if (r_pend || w_any_err) begin
                        r_state <= ST_REPORT;
                        r_irq   <= 1'b1;
                        r_first <= r_pend ? r_pend_src : w_low;
                        r_pend  <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_irq   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_irq   <= 1'b0;
                    r_pend  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CV32E40P_FT_PERSIST_EN
    localparam int               RUN_W    = 8;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(PERSIST_CYCLES - 1);

    logic [RUN_W-1:0] r_run [NSRC];
    logic [NSRC-1:0]  r_perm;

    // Track consecutive error cycles per source and flag permanent faults once the threshold is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run  <= '{default: '0};
            r_perm <= '0;
        end else if (clear_i) begin
            r_run  <= '{default: '0};
            r_perm <= '0;
        end else begin
            for (int k = 0; k < NSRC; k++) begin
                if (!err_i[k]) begin
                    r_run[k] <= '0;
                end else if (r_run[k] == RUN_LAST) begin
                    // This is the PERSIST_CYCLES-th consecutive error cycle. The run
                    // counter stays here, so the count cannot wrap.
                    r_perm[k] <= 1'b1;
                end else begin
                    r_run[k] <= r_run[k] + RUN_W'(1);
                end
            end
        end
    end

    assign perm_fault_o = r_perm;
`else
    assign perm_fault_o = '0;
`endif

    // Readout mux over the registered counters. An out-of-range index reads as zero.
    always_comb begin
        w_rd_cnt = '0;
        if (int'(rd_sel_i) < NSRC) begin
            w_rd_cnt = r_cnt[rd_sel_i];
        end else begin
            w_rd_cnt = '0;
        end
    end

    assign rd_cnt_o    = w_rd_cnt;
    assign sticky_o    = r_sticky;
    assign total_cnt_o = r_total;
    assign first_src_o = r_first;
    assign irq_o       = r_irq;

endmodule

// File: tb/tb_cv32e40p_ft_error_monitor.sv
// Testbench for cv32e40p_ft_error_monitor. The driver applies stimulus on
// the falling edge and advances a reference model written from the
// behavioural rules. It queues the outputs expected after the next rising
// edge. A separate monitor samples the DUT 2 time units after each rising
// edge, pops one expectation and compares against it.
module tb_cv32e40p_ft_error_monitor;

    localparam int NSRC    = 4;
    localparam int CNT_W   = 8;
    localparam int PERSIST = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int M_IDLE  = 0;
    localparam int M_REP   = 1;
    localparam int M_HOLD  = 2;

    logic             clk;
    logic             rst_n;
    logic [3:0]       err_i;
    logic             clear_i;
    logic [1:0]       rd_sel_i;
    logic [7:0]       rd_cnt_o;
    logic [3:0]       sticky_o;
    logic [15:0]      total_cnt_o;
    logic [1:0]       first_src_o;
    logic             irq_o;
    logic             irq_ack_i;
    logic [3:0]       perm_fault_o;

    cv32e40p_ft_error_monitor #(
        .NSRC(NSRC), .CNT_W(CNT_W), .PERSIST_CYCLES(PERSIST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .err_i(err_i), .clear_i(clear_i),
        .rd_sel_i(rd_sel_i), .rd_cnt_o(rd_cnt_o), .sticky_o(sticky_o),
        .total_cnt_o(total_cnt_o), .first_src_o(first_src_o), .irq_o(irq_o),
        .irq_ack_i(irq_ack_i), .perm_fault_o(perm_fault_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [3:0]  sticky;
        logic [7:0]  cnt;
        logic [15:0] total;
        logic [1:0]  first;
        logic        irq;
        logic [3:0]  perm;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;

    // Reference model state.
    bit [3:0] m_sticky;
    int       m_cnt [NSRC];
    int       m_total;
    int       m_mode;
    int       m_first;
    bit       m_pend;
    int       m_psrc;
    int       m_run [NSRC];
    bit [3:0] m_perm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < NSRC; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_sticky = '0; m_total = 0; m_mode = M_IDLE; m_first = 0;
        m_pend = 1'b0; m_psrc = 0; m_perm = '0;
        for (int k = 0; k < NSRC; k++) begin m_cnt[k] = 0; m_run[k] = 0; end
    endtask

    task automatic model_update(input logic [3:0] e, input logic c, input logic a);
        if (c) begin
            m_sticky = '0; m_total = 0; m_perm = '0;
            for (int k = 0; k < NSRC; k++) begin m_cnt[k] = 0; m_run[k] = 0; end
            m_mode = M_IDLE; m_pend = 1'b0;
        end else begin
            for (int k = 0; k < NSRC; k++) begin
                if (e[k]) begin
                    m_sticky[k] = 1'b1;
                    if (m_cnt[k] < CNT_MAX) m_cnt[k]++;
                    m_run[k]++;
`ifdef CV32E40P_FT_PERSIST_EN
                    if (m_run[k] >= PERSIST) m_perm[k] = 1'b1;
`endif
                end else begin
                    m_run[k] = 0;
                end
            end
            if (e != 4'd0 && m_total < 65535) m_total++;
            if (m_mode == M_IDLE) begin
                if (e != 4'd0) begin m_mode = M_REP; m_first = lowest(e); end
            end else begin
                if (e != 4'd0 && !m_pend) begin m_pend = 1'b1; m_psrc = lowest(e); end
                if (m_mode == M_REP) begin
                    if (a) m_mode = M_HOLD;
                end else if (m_pend) begin
                    m_mode = M_REP; m_first = m_psrc; m_pend = 1'b0;
                end else begin
                    m_mode = M_IDLE;
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] e, input logic c, input logic a, input logic [1:0] s);
        exp_t x;
        @(negedge clk);
        err_i = e; clear_i = c; irq_ack_i = a; rd_sel_i = s;
        model_update(e, c, a);
        x.sticky = m_sticky;
        x.cnt    = 8'(m_cnt[s]);
        x.total  = 16'(m_total);
        x.first  = 2'(m_first);
        x.irq    = (m_mode == M_REP);
        x.perm   = m_perm;
        q.push_back(x);
    endtask

    // Monitor: compare the DUT outputs after each rising edge with the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sticky", 32'(sticky_o), 32'(e.sticky));
                chk("rd_cnt", 32'(rd_cnt_o), 32'(e.cnt));
                chk("total", 32'(total_cnt_o), 32'(e.total));
                chk("first_src", 32'(first_src_o), 32'(e.first));
                chk("irq", 32'(irq_o), 32'(e.irq));
                chk("perm", 32'(perm_fault_o), 32'(e.perm));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_sticky"}, 32'(sticky_o), 32'd0);
        chk({tag, "_rd_cnt"}, 32'(rd_cnt_o), 32'd0);
        chk({tag, "_total"}, 32'(total_cnt_o), 32'd0);
        chk({tag, "_first"}, 32'(first_src_o), 32'd0);
        chk({tag, "_irq"}, 32'(irq_o), 32'd0);
        chk({tag, "_perm"}, 32'(perm_fault_o), 32'd0);
    endtask

    initial begin
        logic [3:0] e;
        rst_n = 1'b0; err_i = '0; clear_i = 1'b0; irq_ack_i = 1'b0; rd_sel_i = '0;
        model_reset();
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // A single-cycle error on source 2.
        step(4'b0100, 1'b0, 1'b0, 2'd2);
        step(4'b0000, 1'b0, 1'b1, 2'd2);
        step(4'b0000, 1'b0, 1'b0, 2'd2);
        step(4'b0000, 1'b1, 1'b0, 2'd0);

        // 300 cycles on sources 1 and 3: counters saturate, total does not.
        repeat (300) step(4'b1010, 1'b0, 1'b0, 2'd1);
        step(4'b0000, 1'b0, 1'b0, 2'd3);
        step(4'b0000, 1'b0, 1'b1, 2'd1);
        step(4'b0000, 1'b0, 1'b0, 2'd1);
        step(4'b0000, 1'b0, 1'b0, 2'd1);
        step(4'b0000, 1'b1, 1'b0, 2'd1);

        // Pending event during REPORT, then acknowledge and holdoff.
        step(4'b0001, 1'b0, 1'b0, 2'd0);
        step(4'b1000, 1'b0, 1'b0, 2'd3);
        step(4'b0000, 1'b0, 1'b1, 2'd3);
        step(4'b0000, 1'b0, 1'b0, 2'd3);
        step(4'b0000, 1'b0, 1'b0, 2'd3);
        step(4'b0000, 1'b0, 1'b1, 2'd3);
        step(4'b0000, 1'b0, 1'b0, 2'd3);

        // A clear in the same cycle as an error drops that error.
        step(4'b0001, 1'b1, 1'b0, 2'd0);
        step(4'b0000, 1'b0, 1'b0, 2'd0);

        // Persistence runs on source 0: a run of 3, a gap, then a run of 4.
        repeat (3) step(4'b0001, 1'b0, 1'b0, 2'd0);
        step(4'b0000, 1'b0, 1'b0, 2'd0);
        repeat (4) step(4'b0001, 1'b0, 1'b0, 2'd0);
        repeat (2) step(4'b0000, 1'b0, 1'b0, 2'd0);
        step(4'b0000, 1'b1, 1'b0, 2'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            e = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            step(e, ($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)));
        end

        // Asynchronous reset asserted while a report is open.
        step(4'b0000, 1'b1, 1'b0, 2'd0);
        step(4'b0010, 1'b0, 1'b0, 2'd1);
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        err_i = '0; irq_ack_i = 1'b0; clear_i = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) step(4'b0000, 1'b0, 1'b0, 2'd1);
        step(4'b0100, 1'b0, 1'b0, 2'd2);
        step(4'b0000, 1'b0, 1'b0, 2'd2);

        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
